// File: rtl/fp_stream_if.sv
// Stream bundle around the FP accumulator: operand beats in, packet totals out.
// The slave modport is the accumulator's view; master is the surrounding logic's view.
interface fp_stream_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_sum;
    logic [COUNT_W-1:0] out_count;
    logic               out_overflow;
    logic               out_underflow;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow, out_underflow
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_stream_accumulator.sv
// Per-packet IEEE-754 single-precision summer with a clocked front end, a
// truncating combinational FP adder, sticky overflow/underflow flags and an element count.
module fp_stream_accumulator #(
    parameter int unsigned COUNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    fp_stream_if.slave s
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        acc_q, op_q;
    logic               last_q, pending_q, first_q;
    logic [COUNT_W-1:0] count_q;
    logic               ovf_q, unf_q;

    logic               in_ready, out_valid;
    logic               accept, handshake;
    logic [31:0]        add_res;
    logic               add_ovf, add_unf;

    assign accept    = s.in_valid & in_ready;
    assign handshake = out_valid & s.out_ready;

    // Adder: align smaller magnitude (truncating), add/sub, renormalise.
    // Exponent past 254 -> overflow (signed infinity); below 1 -> underflow (signed zero).
    always_comb begin
        logic [31:0] big, sml;
        logic [7:0]  e_big, diff;
        logic [23:0] m_big, m_sml, m_aln, m_norm;
        logic [24:0] sum;
        logic [4:0]  lz;

        add_res = 32'h0;
        add_ovf = 1'b0;
        add_unf = 1'b0;
        if (acc_q[30:0] >= op_q[30:0]) begin
            big = acc_q;
            sml = op_q;
        end else begin
            big = op_q;
            sml = acc_q;
        end
        e_big = big[30:23];
        m_big = {|big[30:23], big[22:0]};
        m_sml = {|sml[30:23], sml[22:0]};
        diff  = e_big - sml[30:23];
        m_aln = (diff > 8'd23) ? 24'h0 : (m_sml >> diff);
        if (big[31] == sml[31]) sum = {1'b0, m_big} + {1'b0, m_aln};
        else                    sum = {1'b0, m_big} - {1'b0, m_aln};
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (sum[i]) lz = 5'(23 - i);
        end
        m_norm = sum[23:0] << lz;

        if (sum[24]) begin
            if (e_big >= 8'd254) begin
                add_ovf = 1'b1;
                add_res = {big[31], 8'hFF, 23'h0};
            end else begin
                add_res = {big[31], e_big + 8'd1, sum[23:1]};
            end
        end else if (sum == 25'h0) begin
            add_res = 32'h0;
        end else if ({3'b000, lz} >= e_big) begin
            add_unf = 1'b1;
            add_res = {big[31], 31'h0};
        end else begin
            add_res = {big[31], e_big - {3'b000, lz}, m_norm[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StAcc;
            StAcc:   if (pending_q && last_q) state_d = StDone;
            StDone:  if (s.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != StDone) & ~pending_q;
        out_valid = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= 32'h0;
            op_q      <= 32'h0;
            last_q    <= 1'b0;
            pending_q <= 1'b0;
            first_q   <= 1'b1;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= s.in_data;
                last_q    <= s.in_last;
                pending_q <= 1'b1;
            end
            if (pending_q) begin
                // First element bypasses the adder so a lone value passes bit-exact.
                if (first_q) begin
                    acc_q <= op_q;
                end else begin
                    acc_q <= add_res;
                    ovf_q <= ovf_q | add_ovf;
                    unf_q <= unf_q | add_unf;
                end
                if (count_q != '1) count_q <= count_q + 1'b1;
                first_q   <= 1'b0;
                pending_q <= 1'b0;
            end
            if (handshake) begin
                acc_q   <= 32'h0;
                count_q <= '0;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
                first_q <= 1'b1;
            end
        end
    end

    assign s.in_ready      = in_ready;
    assign s.out_valid     = out_valid;
    assign s.out_sum       = acc_q;
    assign s.out_count     = count_q;
    assign s.out_overflow  = ovf_q;
    assign s.out_underflow = unf_q;

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator: table of packets with hand-computed totals,
// plus sequences for backpressure, mid-packet reset and count saturation.
module tb_fp_stream_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_stream_if #(.COUNT_W(8)) bus ();

    fp_stream_accumulator #(.COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    typedef struct {
        int          n;
        logic [95:0] d;        // {beat2, beat1, beat0}
        logic [31:0] sum;
        logic        chk_sum;
        int          cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_accept", {31'h0, bus.in_ready}, 32'h0);
    endtask

    task automatic finish_packet(input string name, input logic [31:0] sum, input logic chk_sum,
                                 input int cnt, input logic ovf, input logic unf);
        check({name, "_latency_lo"}, {31'h0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check({name, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
        if (chk_sum) check({name, "_sum"}, bus.out_sum, sum);
        check({name, "_count"}, {24'h0, bus.out_count}, cnt);
        check({name, "_ovf"}, {31'h0, bus.out_overflow}, {31'h0, ovf});
        check({name, "_unf"}, {31'h0, bus.out_underflow}, {31'h0, unf});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_cleared"}, {31'h0, bus.out_valid}, 32'h0);
        check({name, "_ready_restart"}, {31'h0, bus.in_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] held_sum;

        vecs[0] = '{n: 1, d: {32'h0, 32'h0, 32'h40400000}, sum: 32'h40400000, chk_sum: 1'b1,
                    cnt: 1, ovf: 1'b0, unf: 1'b0};
        vecs[1] = '{n: 2, d: {32'h0, 32'hC1008001, 32'hC1040001}, sum: 32'hC1824001,
                    chk_sum: 1'b1, cnt: 2, ovf: 1'b0, unf: 1'b0};
        vecs[2] = '{n: 3, d: {32'h40400000, 32'h40000000, 32'h3F800000}, sum: 32'h40C00000,
                    chk_sum: 1'b1, cnt: 3, ovf: 1'b0, unf: 1'b0};
        vecs[3] = '{n: 2, d: {32'h0, 32'h7F008001, 32'h7F240201}, sum: 32'h0, chk_sum: 1'b0,
                    cnt: 2, ovf: 1'b1, unf: 1'b0};
        vecs[4] = '{n: 2, d: {32'h0, 32'h80A08102, 32'h00A40201}, sum: 32'h0, chk_sum: 1'b0,
                    cnt: 2, ovf: 1'b0, unf: 1'b1};
        vecs[5] = '{n: 2, d: {32'h0, 32'hC0400000, 32'h40000000}, sum: 32'hBF800000,
                    chk_sum: 1'b1, cnt: 2, ovf: 1'b0, unf: 1'b0};
        vecs[6] = '{n: 2, d: {32'h0, 32'hBF800000, 32'h3F800000}, sum: 32'h00000000,
                    chk_sum: 1'b1, cnt: 2, ovf: 1'b0, unf: 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst_out_sum", bus.out_sum, 32'h0);
        check("rst_out_count", {24'h0, bus.out_count}, 32'h0);

        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                // Vary inter-beat gaps so the held-accumulator path is exercised.
                repeat (v % 3) @(negedge clk);
                send_beat(vecs[v].d[b*32 +: 32], (b == vecs[v].n - 1));
            end
            finish_packet($sformatf("vec%0d", v), vecs[v].sum, vecs[v].chk_sum, vecs[v].cnt,
                          vecs[v].ovf, vecs[v].unf);
        end

        // Backpressure: total must hold while downstream stalls; inputs ignored.
        send_beat(32'h40400000, 1'b1);
        @(negedge clk);
        check("bp_valid", {31'h0, bus.out_valid}, 32'h1);
        held_sum = bus.out_sum;
        check("bp_sum", held_sum, 32'h40400000);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'h0, bus.out_valid}, 32'h1);
            check("bp_hold_sum", bus.out_sum, 32'h40400000);
            check("bp_hold_count", {24'h0, bus.out_count}, 32'h1);
            check("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_released", {31'h0, bus.out_valid}, 32'h0);
        check("bp_ready_next", {31'h0, bus.in_ready}, 32'h1);

        // Reset after the 2nd of 3 beats discards the partial packet.
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'h40000000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("mid_rst_ready", {31'h0, bus.in_ready}, 32'h1);
        check("mid_rst_count", {24'h0, bus.out_count}, 32'h0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_out", {31'h0, bus.out_valid}, 32'h0);
        send_beat(32'h3F800000, 1'b1);
        finish_packet("after_rst", 32'h3F800000, 1'b1, 1, 1'b0, 1'b0);

        // 256 ones: count pins at 255 while the sum keeps going to 256.0.
        for (int b = 0; b < 256; b++) send_beat(32'h3F800000, (b == 255));
        finish_packet("sat", 32'h43800000, 1'b1, 255, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
